divider_arbiter_module: RTL and testbench

- Shares one signed divider (Start_Sig/Done_Sig handshake, Dividend/Divisor in, Quotient/Reminder out) among N_REQ requesters.
- Round-robin arbitration, operand latching and result routing.
- Intercepts divide-by-zero without starting the divider.
- Watchdog aborts a stalled divider operation.
- Sits between client FSMs and a single divider_module_3 instance.

---
 rtl/divider_arb_pkg.sv | 18 +
 rtl/divider_arbiter_module_if.sv | 38 +++
 rtl/rr_pick_module.sv | 31 +++
 rtl/divider_arbiter_module.sv | 110 +++++++++++
 tb/tb_divider_arbiter_module.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_arb_pkg.sv
// Shared types and constants for the divider arbiter: FSM encoding,
// error-result values and default sizing.
package divider_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_TIMEOUT = 64;

    // Quotient reported on divide-by-zero or watchdog abort.
    localparam int ERR_QUOTIENT = 0;

endpackage

// File: rtl/divider_arbiter_module_if.sv
// Requester-side and divider-side signal bundle of the divider arbiter.
// The arbiter uses the slave modport; clients and the divider use master.
interface divider_arbiter_module_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       Req_Start_Sig;
    logic [N_REQ*WIDTH-1:0] Req_Dividend;
    logic [N_REQ*WIDTH-1:0] Req_Divisor;
    logic [N_REQ-1:0]       Req_Done_Sig;
    logic                   Err_Sig;
    logic [WIDTH-1:0]       Quotient;
    logic [WIDTH-1:0]       Reminder;
    logic [ID_W-1:0]        Grant_Id;
    logic                   Busy;
    logic                   Div_Start_Sig;
    logic [WIDTH-1:0]       Div_Dividend;
    logic [WIDTH-1:0]       Div_Divisor;
    logic                   Div_Done_Sig;
    logic [WIDTH-1:0]       Div_Quotient;
    logic [WIDTH-1:0]       Div_Reminder;

    modport slave (
        input  Req_Start_Sig, Req_Dividend, Req_Divisor,
        input  Div_Done_Sig, Div_Quotient, Div_Reminder,
        output Req_Done_Sig, Err_Sig, Quotient, Reminder, Grant_Id, Busy,
        output Div_Start_Sig, Div_Dividend, Div_Divisor
    );

    modport master (
        output Req_Start_Sig, Req_Dividend, Req_Divisor,
        output Div_Done_Sig, Div_Quotient, Div_Reminder,
        input  Req_Done_Sig, Err_Sig, Quotient, Reminder, Grant_Id, Busy,
        input  Div_Start_Sig, Div_Dividend, Div_Divisor
    );

endinterface

// File: rtl/rr_pick_module.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last_grant+1 with wrap-around.
module rr_pick_module #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] request,
    input  logic [ID_W-1:0]  last_grant,
    output logic             any_req,
    output logic [ID_W-1:0]  winner
);

    logic found;
    int   idx;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        any_req = |request;
        winner  = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && request[idx]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_arbiter_module.sv
// Shares one signed divider among N_REQ requesters: round-robin grant,
// operand latching, divide-by-zero interception and a stall watchdog.
module divider_arbiter_module
    import divider_arb_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input logic                     CLK,
    input logic                     RSTn,
    divider_arbiter_module_if.slave bus
);

    localparam int               WD_W    = $clog2(TIMEOUT);
    localparam logic [N_REQ-1:0] REQ_ONE = N_REQ'(1);

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [WD_W-1:0]   watchdog;
    logic              any_req;
    logic [ID_W-1:0]   winner;
    logic [WIDTH-1:0]  win_dividend;
    logic [WIDTH-1:0]  win_divisor;

    rr_pick_module #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .request    (bus.Req_Start_Sig),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    assign win_dividend = bus.Req_Dividend[int'(winner)*WIDTH +: WIDTH];
    assign win_divisor  = bus.Req_Divisor[int'(winner)*WIDTH +: WIDTH];

    // NOTE: state and outputs update with non-blocking assignments so every
    // branch sees the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state             <= IDLE;
            last_grant        <= ID_W'(N_REQ - 1);  // requester 0 scanned first
            watchdog          <= '0;
            bus.Req_Done_Sig  <= '0;
            bus.Err_Sig       <= 1'b0;
            bus.Quotient      <= '0;
            bus.Reminder      <= '0;
            bus.Grant_Id      <= '0;
            bus.Busy          <= 1'b0;
            bus.Div_Start_Sig <= 1'b0;
            bus.Div_Dividend  <= '0;
            bus.Div_Divisor   <= '0;
        end else begin
            bus.Req_Done_Sig <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.Div_Dividend <= win_dividend;
                        bus.Div_Divisor  <= win_divisor;
                        bus.Grant_Id     <= winner;
                        bus.Busy         <= 1'b1;
                        if (win_divisor == '0) begin
                            // Divide-by-zero answered locally; the divider is never started.
                            state            <= DONE;
                            bus.Quotient     <= WIDTH'(ERR_QUOTIENT);
                            bus.Reminder     <= win_dividend;
                            bus.Err_Sig      <= 1'b1;
                            bus.Req_Done_Sig <= REQ_ONE << winner;
                        end else begin
                            state             <= RUN;
                            bus.Div_Start_Sig <= 1'b1;
                            watchdog          <= '0;
                        end
                    end
                end
                RUN: begin
                    watchdog <= watchdog + 1'b1;
                    if (bus.Div_Done_Sig) begin
                        state             <= DONE;
                        bus.Div_Start_Sig <= 1'b0;
                        bus.Quotient      <= bus.Div_Quotient;
                        bus.Reminder      <= bus.Div_Reminder;
                        bus.Err_Sig       <= 1'b0;
                        bus.Req_Done_Sig  <= REQ_ONE << bus.Grant_Id;
                    end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
                        state             <= DONE;
                        bus.Div_Start_Sig <= 1'b0;
                        bus.Quotient      <= WIDTH'(ERR_QUOTIENT);
                        bus.Reminder      <= '0;
                        bus.Err_Sig       <= 1'b1;
                        bus.Req_Done_Sig  <= REQ_ONE << bus.Grant_Id;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    bus.Busy   <= 1'b0;
                    last_grant <= bus.Grant_Id;
                end
                default: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_arbiter_module.sv
// Directed bench for divider_arbiter_module with a behavioural 8-cycle
// signed divider that can be told to hang or to emit a stray done pulse.
module tb_divider_arbiter_module;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    divider_arbiter_module_if #(.N_REQ(4), .WIDTH(8)) bus ();

    divider_arbiter_module #(
        .N_REQ   (4),
        .WIDTH   (8),
        .TIMEOUT (64)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus.slave)
    );

    // Behavioural divider: done in the 8th cycle of Start_Sig high.
    logic div_hang = 1'b0;
    logic div_spur = 1'b0;
    int   div_cnt;
    logic signed [7:0] m_dd, m_dv;

    always @(posedge CLK) begin
        if (!bus.Div_Start_Sig) div_cnt <= 0;
        else                    div_cnt <= div_cnt + 1;
    end

    assign m_dd = $signed(bus.Div_Dividend);
    assign m_dv = $signed(bus.Div_Divisor);
    assign bus.Div_Done_Sig = (bus.Div_Start_Sig && div_cnt == 7 && !div_hang) || div_spur;
    assign bus.Div_Quotient = (m_dv == 0) ? 8'h00 : 8'(m_dd / m_dv);
    assign bus.Div_Reminder = (m_dv == 0) ? 8'h00 : 8'(m_dd % m_dv);

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.Req_Dividend[i*8 +: 8] = a;
        bus.Req_Divisor[i*8 +: 8]  = b;
    endtask

    logic [3:0] res_done;
    logic       res_err;
    logic [7:0] res_q, res_r;
    logic [1:0] res_gid;
    int         res_cycles;
    int         res_hi;
    bit         res_saw;

    // Waits (bounded) for a completion pulse; cycles counts the calling cycle as 1.
    task automatic wait_done(input bit drop);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        res_cycles = 1;
        res_hi = 0;
        res_saw = 1'b0;
        res_done = '0;
        res_err = 1'b0;
        res_q = '0;
        res_r = '0;
        res_gid = '0;
        while (!got && n < 200) begin
            @(negedge CLK);
            n++;
            res_cycles++;
            if (bus.Div_Start_Sig) begin
                res_saw = 1'b1;
                res_hi++;
            end
            if (bus.Req_Done_Sig != '0) begin
                got = 1'b1;
                res_done = bus.Req_Done_Sig;
                res_err  = bus.Err_Sig;
                res_q    = bus.Quotient;
                res_r    = bus.Reminder;
                res_gid  = bus.Grant_Id;
                if (drop) bus.Req_Start_Sig = bus.Req_Start_Sig & ~bus.Req_Done_Sig;
            end
        end
    endtask

    int gap;

    initial begin
        bus.Req_Start_Sig = '0;
        bus.Req_Dividend  = '0;
        bus.Req_Divisor   = '0;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_done",   32'(bus.Req_Done_Sig), 32'h0);
        check("rst_err",    32'(bus.Err_Sig), 32'h0);
        check("rst_q_r",    32'({bus.Quotient, bus.Reminder}), 32'h0);
        check("rst_grant",  32'(bus.Grant_Id), 32'h0);
        check("rst_busy",   32'(bus.Busy), 32'h0);
        check("rst_start",  32'(bus.Div_Start_Sig), 32'h0);
        check("rst_ops",    32'({bus.Div_Dividend, bus.Div_Divisor}), 32'h0);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        // Single requester, 13/2
        set_op(0, 8'd13, 8'd2);
        bus.Req_Start_Sig = 4'b0001;
        wait_done(1'b1);
        check("t1_done",    32'(res_done), 32'h1);
        check("t1_latency", 32'(res_cycles), 32'd10);
        check("t1_q",       32'(res_q), 32'h06);
        check("t1_r",       32'(res_r), 32'h01);
        check("t1_err",     32'(res_err), 32'h0);
        check("t1_gid",     32'(res_gid), 32'h0);
        @(negedge CLK);
        check("t1_pulse_1cyc", 32'(bus.Req_Done_Sig), 32'h0);
        check("t1_idle_busy",  32'(bus.Busy), 32'h0);
        check("t1_q_held",     32'(bus.Quotient), 32'h06);

        // -13 / -2, operands and busy observed mid-operation
        set_op(0, 8'hF3, 8'hFE);
        bus.Req_Start_Sig = 4'b0001;
        repeat (3) @(negedge CLK);
        check("t1b_busy",  32'(bus.Busy), 32'h1);
        check("t1b_start", 32'(bus.Div_Start_Sig), 32'h1);
        check("t1b_ops",   32'({bus.Div_Dividend, bus.Div_Divisor}), 32'hF3FE);
        bus.Req_Start_Sig = 4'b0000;  // dropping mid-run must not cancel
        wait_done(1'b1);
        check("t1b_done", 32'(res_done), 32'h1);
        check("t1b_q_r",  32'({res_q, res_r}), 32'h06FF);

        // Stray divider done while idle is ignored
        div_spur = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("spur_done", 32'(bus.Req_Done_Sig), 32'h0);
        check("spur_busy", 32'(bus.Busy), 32'h0);
        div_spur = 1'b0;
        @(negedge CLK);

        // Divide-by-zero on requester 3
        set_op(3, 8'hF7, 8'h00);
        bus.Req_Start_Sig = 4'b1000;
        wait_done(1'b1);
        check("dz_done",    32'(res_done), 32'h8);
        check("dz_latency", 32'(res_cycles), 32'd2);
        check("dz_err",     32'(res_err), 32'h1);
        check("dz_q_r",     32'({res_q, res_r}), 32'h00F7);
        check("dz_nostart", 32'(res_saw), 32'h0);
        @(negedge CLK);

        // Three simultaneous requests served 0,1,2
        set_op(0, 8'd13, 8'hFE);
        set_op(1, 8'hF3, 8'd2);
        set_op(2, 8'd9, 8'd6);
        bus.Req_Start_Sig = 4'b0111;
        wait_done(1'b1);
        check("rr_a_done", 32'(res_done), 32'h1);
        check("rr_a_q_r",  32'({res_q, res_r}), 32'hFA01);
        gap = 0;
        while (!bus.Div_Start_Sig && gap < 10) begin
            @(negedge CLK);
            gap++;
        end
        check("start_gap", 32'(gap >= 1 && gap <= 2), 32'h1);
        wait_done(1'b1);
        check("rr_b_done", 32'(res_done), 32'h2);
        check("rr_b_q_r",  32'({res_q, res_r}), 32'hFAFF);
        wait_done(1'b1);
        check("rr_c_done", 32'(res_done), 32'h4);
        check("rr_c_q_r",  32'({res_q, res_r}), 32'h0103);
        @(negedge CLK);

        // Watchdog: divider never answers
        div_hang = 1'b1;
        set_op(1, 8'd50, 8'd5);
        bus.Req_Start_Sig = 4'b0010;
        wait_done(1'b1);
        check("wd_done",     32'(res_done), 32'h2);
        check("wd_start_hi", 32'(res_hi), 32'd64);
        check("wd_err",      32'(res_err), 32'h1);
        check("wd_q_r",      32'({res_q, res_r}), 32'h0000);
        div_hang = 1'b0;
        @(negedge CLK);
        set_op(3, 8'd100, 8'd7);
        bus.Req_Start_Sig = 4'b1000;
        wait_done(1'b1);
        check("wd_next_done", 32'(res_done), 32'h8);
        check("wd_next_q_r",  32'({res_q, res_r}), 32'h0E02);
        check("wd_next_err",  32'(res_err), 32'h0);
        @(negedge CLK);

        // Fairness: requesters 0 and 3 keep requesting
        set_op(0, 8'd20, 8'd3);
        set_op(3, 8'hEC, 8'd3);
        bus.Req_Start_Sig = 4'b1001;
        wait_done(1'b0);
        check("fair_1", 32'({res_done, res_q, res_r}), 32'h10602);
        wait_done(1'b0);
        check("fair_2", 32'({res_done, res_q, res_r}), 32'h8FAFE);
        wait_done(1'b0);
        check("fair_3", 32'({res_done, res_q, res_r}), 32'h10602);
        wait_done(1'b1);
        check("fair_4", 32'({res_done, res_q, res_r}), 32'h8FAFE);
        bus.Req_Start_Sig = 4'b0000;
        repeat (2) @(negedge CLK);

        // Reset during RUN
        set_op(2, 8'd40, 8'd3);
        bus.Req_Start_Sig = 4'b0100;
        repeat (6) @(negedge CLK);
        check("mid_busy_pre", 32'(bus.Busy), 32'h1);
        RSTn = 1'b0;
        #1;
        check("mid_start", 32'(bus.Div_Start_Sig), 32'h0);
        check("mid_outs",  32'({bus.Busy, bus.Err_Sig, bus.Grant_Id, bus.Quotient, bus.Reminder}), 32'h0);
        bus.Req_Start_Sig = 4'b0000;
        set_op(0, 8'd7, 8'd2);
        set_op(1, 8'd9, 8'd4);
        bus.Req_Start_Sig = 4'b0011;
        @(negedge CLK);
        @(negedge CLK);
        check("mid_no_done", 32'(bus.Req_Done_Sig), 32'h0);
        RSTn = 1'b1;
        wait_done(1'b1);
        check("post_rst_1", 32'({res_done, res_q, res_r}), 32'h10301);
        wait_done(1'b1);
        check("post_rst_2", 32'({res_done, res_q, res_r}), 32'h20201);
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
